prio_arbiter_rr: RTL and testbench

- Parametrised, registered N-input priority encoder/arbiter; the sequential successor of the team's 4-input combinational priority encoder.
- Encodes an N-bit request vector into a registered grant index plus one-hot grant.
- Two modes: fixed priority (highest index wins) and round-robin.
- Holds each grant until the consumer acknowledges it.
- Sits between multiple requesters and a single shared resource.

---
 rtl/prio_arbiter_rr_if.sv | 27 ++
 rtl/prio_arbiter_rr.sv | 148 ++++++++++++++
 tb/tb_prio_arbiter_rr.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/prio_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
// prio_arbiter_rr_if : request/grant bundle between requesters and arbiter
// Optional macro ARB_TIMEOUT_EN adds the timeout pulse. Rev 1.0
// ============================================================================
interface prio_arbiter_rr_if #(
  parameter int N = 4
);
  localparam int IDX_W = $clog2(N);

  logic             mode;
  logic [N-1:0]     req;
  logic             ack;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [N-1:0]     gnt_onehot;
`ifdef ARB_TIMEOUT_EN
  logic             timeout;

  modport master (output mode, req, ack, input gnt_valid, gnt_idx, gnt_onehot, timeout);
  modport slave  (input mode, req, ack, output gnt_valid, gnt_idx, gnt_onehot, timeout);
`else
  modport master (output mode, req, ack, input gnt_valid, gnt_idx, gnt_onehot);
  modport slave  (input mode, req, ack, output gnt_valid, gnt_idx, gnt_onehot);
`endif
endinterface
`default_nettype wire

// File: rtl/prio_arbiter_rr.sv
`default_nettype none
// ============================================================================
// prio_arbiter_rr : registered N-input fixed-priority / round-robin arbiter
// Optional macro ARB_TIMEOUT_EN releases unacked grants after TIMEOUT cycles. Rev 1.0
// ============================================================================
module prio_arbiter_rr #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prio_arbiter_rr_if.slave     bus
);
  localparam int IDX_W = $clog2(N);

  if (N < 2 || TIMEOUT < 2) begin : g_bad_param
    $error("prio_arbiter_rr: N and TIMEOUT must both be >= 2");
  end

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     onehot_q, onehot_d;
  logic             mode_q, mode_d;

  logic [IDX_W-1:0] w_fp_idx;
  logic [IDX_W-1:0] w_rr_idx;
  logic [IDX_W-1:0] w_rr_probe;
  logic [IDX_W-1:0] w_win_idx;
  logic [IDX_W-1:0] w_next_ptr;
  logic             w_start;
  logic             w_expire;

  // Ascending scan so the highest set index is the last one written.
  always_comb begin
    w_fp_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.req[i]) w_fp_idx = IDX_W'(i);
    end
  end

  // Descending offset scan: the smallest offset from ptr_q wins.
  always_comb begin
    w_rr_idx   = '0;
    w_rr_probe = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_rr_probe = IDX_W'((int'(ptr_q) + k) % N);
      if (bus.req[w_rr_probe]) w_rr_idx = w_rr_probe;
    end
  end

  assign w_win_idx  = bus.mode ? w_rr_idx : w_fp_idx;
  assign w_next_ptr = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);
  assign w_start    = (state_q == S_IDLE) && (|bus.req);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  assign w_expire = (state_q == S_GRANT) && !bus.ack && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (w_start) begin
      cnt_d = '0;
    end else if (state_q == S_GRANT && !bus.ack) begin
      cnt_d     = cnt_q + CNT_W'(1);
      timeout_d = w_expire;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign w_expire = 1'b0;
`endif

  // mode_q remembers the mode the grant was issued under, so a mode change
  // during GRANT only affects the next arbitration, not this pointer update.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    onehot_d = onehot_q;
    mode_d   = mode_q;
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          state_d             = S_GRANT;
          mode_d              = bus.mode;
          idx_d               = w_win_idx;
          onehot_d            = '0;
          onehot_d[w_win_idx] = 1'b1;
        end
      end
      S_GRANT: begin
        if (bus.ack || w_expire) begin
          state_d  = S_IDLE;
          onehot_d = '0;
          if (mode_q) ptr_d = w_next_ptr;
        end
      end
      default: begin
        state_d  = S_IDLE;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      ptr_q    <= '0;
      onehot_q <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      onehot_q <= onehot_d;
      mode_q   <= mode_d;
    end
  end

  assign bus.gnt_valid  = (state_q == S_GRANT);
  assign bus.gnt_idx    = idx_q;
  assign bus.gnt_onehot = onehot_q;

endmodule
`default_nettype wire

// File: tb/tb_prio_arbiter_rr.sv
`default_nettype none
// ============================================================================
// tb_prio_arbiter_rr : directed scoreboard bench for prio_arbiter_rr (N=4)
// Timeout steps are included when ARB_TIMEOUT_EN is defined. Rev 1.0
// ============================================================================
module tb_prio_arbiter_rr;
  logic clk;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [1:0] exp_q[$];

  prio_arbiter_rr_if #(.N(4)) bus ();

  prio_arbiter_rr #(.N(4), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive a request, expect the grant one edge later, then ack it.
  task automatic grant_ack(input logic [3:0] r, input logic [1:0] e, input string tag);
    logic [1:0] x;
    bus.req = r;
    exp_q.push_back(e);
    step();
    x = exp_q.pop_front();
    chk({tag, "_valid"},  32'(bus.gnt_valid),  32'd1);
    chk({tag, "_idx"},    32'(bus.gnt_idx),    32'(x));
    chk({tag, "_onehot"}, 32'(bus.gnt_onehot), 32'(4'b0001 << x));
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    chk({tag, "_rel_valid"},  32'(bus.gnt_valid),  32'd0);
    chk({tag, "_rel_onehot"}, 32'(bus.gnt_onehot), 32'd0);
  endtask

  initial begin
    logic [3:0] fp_req [8];
    logic [1:0] fp_exp [8];
    logic [1:0] rr_exp [5];
    logic [1:0] x;

    fp_req = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000};
    fp_exp = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst_n    = 1'b0;
    bus.mode = 1'b0;
    bus.req  = '0;
    bus.ack  = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    for (int c = 0; c < 5; c++) begin
      step();
      chk("reset_valid",  32'(bus.gnt_valid),  32'd0);
      chk("reset_onehot", 32'(bus.gnt_onehot), 32'd0);
      chk("reset_idx",    32'(bus.gnt_idx),    32'd0);
    end

    // ack while idle must not create or disturb anything
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    chk("idle_ack_valid", 32'(bus.gnt_valid), 32'd0);

    bus.mode = 1'b0;
    for (int p = 0; p < 8; p++) grant_ack(fp_req[p], fp_exp[p], "fixed");

    bus.mode = 1'b1;
    for (int g = 0; g < 5; g++) grant_ack(4'b1111, rr_exp[g], "rr_fair");

    // pointer now 1; grant 2 moves it to 3, then 0011 must wrap to 0
    grant_ack(4'b0100, 2'd2, "rr_pre");
    bus.req = 4'b0011;
    exp_q.push_back(2'd0);
    step();
    x = exp_q.pop_front();
    chk("wrap_valid", 32'(bus.gnt_valid), 32'd1);
    chk("wrap_idx",   32'(bus.gnt_idx),   32'(x));
    bus.req = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("hold_valid",  32'(bus.gnt_valid),  32'd1);
      chk("hold_idx",    32'(bus.gnt_idx),    32'd0);
      chk("hold_onehot", 32'(bus.gnt_onehot), 32'd1);
    end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    chk("hold_rel_valid", 32'(bus.gnt_valid), 32'd0);

    // pointer is 1 here; grant 3, then reset between edges
    bus.req = 4'b1000;
    exp_q.push_back(2'd3);
    step();
    x = exp_q.pop_front();
    chk("midrst_grant_idx", 32'(bus.gnt_idx), 32'(x));
    bus.req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid",  32'(bus.gnt_valid),  32'd0);
    chk("midrst_onehot", 32'(bus.gnt_onehot), 32'd0);
    chk("midrst_idx",    32'(bus.gnt_idx),    32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    grant_ack(4'b1111, 2'd0, "post_rst_rr");

`ifdef ARB_TIMEOUT_EN
    bus.mode = 1'b0;
    bus.req  = 4'b0100;
    step();
    bus.req = '0;
    chk("to_idx", 32'(bus.gnt_idx), 32'd2);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) step();
      chk("to_hold_valid", 32'(bus.gnt_valid), 32'd1);
      chk("to_hold_pulse", 32'(bus.timeout),   32'd0);
    end
    step();
    chk("to_expire_valid", 32'(bus.gnt_valid), 32'd0);
    chk("to_expire_pulse", 32'(bus.timeout),   32'd1);
    step();
    chk("to_after_pulse", 32'(bus.timeout), 32'd0);

    bus.req = 4'b0100;
    step();
    bus.req = '0;
    for (int c = 1; c < 16; c++) step();
    chk("to_ack16_valid", 32'(bus.gnt_valid), 32'd1);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    chk("to_ack16_rel",   32'(bus.gnt_valid), 32'd0);
    chk("to_ack16_pulse", 32'(bus.timeout),   32'd0);
    step();
    chk("to_ack16_after", 32'(bus.timeout),   32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
